rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
//============================================================================
// Module   : rx_frame_ctrl
// Brief    : Byte-stream frame receiver (SYNC, 4 payload bytes, checksum)
//            with inter-byte timeout and a single-entry frame output.
// Revision : 1.0 - initial release
//============================================================================
module rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hAA,
    parameter logic [15:0] TIMEOUT   = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_perr,
    output logic [31:0] frm_data,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic        err_parity,
    output logic        err_cksum,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [15:0] c_TIMER_LAST = TIMEOUT - 16'd1;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_sum;
    logic [15:0] r_timer;
    logic [31:0] r_payload;
    logic [31:0] r_frm_data;
    logic        r_frm_valid;
    logic        r_err_parity;
    logic        r_err_cksum;
    logic        r_err_timeout;
    logic        r_err_overrun;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [1:0]  w_idx_nxt;
    logic [7:0]  w_sum_nxt;
    logic [15:0] w_timer_nxt;
    logic [15:0] w_timer_inc;
    logic [31:0] w_payload_nxt;
    logic        w_good_byte;
    logic        w_complete;
    logic        w_parity_ev;
    logic        w_cksum_ev;
    logic        w_timeout_ev;

    assign w_good_byte = rx_valid & ~rx_perr;
    assign w_timer_inc = r_timer + 16'd1;

    // Frame-parsing FSM: next state, datapath updates and error events.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_sum_nxt     = r_sum;
        w_timer_nxt   = r_timer;
        w_payload_nxt = r_payload;
        w_complete    = 1'b0;
        w_parity_ev   = 1'b0;
        w_cksum_ev    = 1'b0;
        w_timeout_ev  = 1'b0;

        case (r_state)
            IDLE: begin
                w_timer_nxt = 16'd0;
                if (w_good_byte && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = PAYLOAD;
                    w_idx_nxt   = 2'd0;
                    w_sum_nxt   = 8'd0;
                end
            end

            PAYLOAD, CHECK: begin
                if (rx_valid) begin
                    // A byte always beats a coincident timeout.
                    w_timer_nxt = 16'd0;
                    if (rx_perr) begin
                        w_parity_ev = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_state == PAYLOAD) begin
                        case (r_idx)
                            2'd0:    w_payload_nxt[31:24] = rx_data;
                            2'd1:    w_payload_nxt[23:16] = rx_data;
                            2'd2:    w_payload_nxt[15:8]  = rx_data;
                            default: w_payload_nxt[7:0]   = rx_data;
                        endcase
                        w_sum_nxt = r_sum + rx_data;
                        w_idx_nxt = r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            w_state_nxt = CHECK;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        if (rx_data == r_sum) begin
                            w_complete = 1'b1;
                        end else begin
                            w_cksum_ev = 1'b1;
                        end
                    end
                end else if (w_timer_inc == c_TIMER_LAST) begin
                    w_timeout_ev = 1'b1;
                    w_timer_nxt  = 16'd0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    logic [31:0] w_frm_data_nxt;
    logic        w_frm_valid_nxt;
    logic        w_overrun_ev;

    // Single-entry output holding register; a completed frame only lands
    // if the slot is empty or being drained in the same cycle.
    always_comb begin
        w_frm_data_nxt  = r_frm_data;
        w_frm_valid_nxt = r_frm_valid;
        w_overrun_ev    = 1'b0;
        if (r_frm_valid && frm_ready) begin
            w_frm_valid_nxt = 1'b0;
        end
        if (w_complete) begin
            if (!r_frm_valid || frm_ready) begin
                w_frm_data_nxt  = w_payload_nxt;
                w_frm_valid_nxt = 1'b1;
            end else begin
                w_overrun_ev = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= 2'd0;
            r_sum         <= 8'd0;
            r_timer       <= 16'd0;
            r_payload     <= 32'd0;
            r_frm_data    <= 32'd0;
            r_frm_valid   <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_cksum   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_sum         <= w_sum_nxt;
            r_timer       <= w_timer_nxt;
            r_payload     <= w_payload_nxt;
            r_frm_data    <= w_frm_data_nxt;
            r_frm_valid   <= w_frm_valid_nxt;
            r_err_parity  <= w_parity_ev;
            r_err_cksum   <= w_cksum_ev;
            r_err_timeout <= w_timeout_ev;
            r_err_overrun <= w_overrun_ev;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign frm_data    = r_frm_data;
    assign frm_valid   = r_frm_valid;
    assign err_parity  = r_err_parity;
    assign err_cksum   = r_err_cksum;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_rx_frame_ctrl
// Brief    : Directed self-checking bench for rx_frame_ctrl (TIMEOUT=16).
// Revision : 1.0 - initial release
//============================================================================
module tb_rx_frame_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_perr;
    logic [31:0] frm_data;
    logic        frm_valid;
    logic        frm_ready;
    logic        err_parity;
    logic        err_cksum;
    logic        err_timeout;
    logic        err_overrun;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rx_frame_ctrl #(
        .SYNC_BYTE (8'hAA),
        .TIMEOUT   (16'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .frm_data    (frm_data),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .err_parity  (err_parity),
        .err_cksum   (err_cksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [3:0] w_errs = {err_parity, err_cksum, err_timeout, err_overrun};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one byte for exactly one rising edge
    // and returns at the following negedge.
    task automatic send(input logic [7:0] d, input logic p);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_perr  = p;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] ck);
        send(8'hAA, 1'b0);
        send(b0, 1'b0);
        send(b1, 1'b0);
        send(b2, 1'b0);
        send(b3, 1'b0);
        send(ck, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_perr   = 1'b0;
        frm_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",  frm_data, 32'h0);
        chk("reset_valid", {31'd0, frm_valid}, 32'd0);
        chk("reset_errs",  {28'd0, w_errs}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-sync bytes and a corrupted sync are ignored in IDLE
        send(8'h55, 1'b0);
        send(8'hAA, 1'b1);
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);
        chk("idle_ignore_errs", {28'd0, w_errs}, 32'd0);

        // Good frame
        send(8'hAA, 1'b0);
        chk("sync_busy", {31'd0, busy}, 32'd1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h0A, 1'b0);
        chk("good_valid", {31'd0, frm_valid}, 32'd1);
        chk("good_data",  frm_data, 32'h01020304);
        chk("good_errs",  {28'd0, w_errs}, 32'd0);
        chk("good_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("good_valid_drop", {31'd0, frm_valid}, 32'd0);

        // Bad checksum (sum is A0)
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h00);
        chk("cksum_errs",  {28'd0, w_errs}, 32'b0100);
        chk("cksum_valid", {31'd0, frm_valid}, 32'd0);
        chk("cksum_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("cksum_pulse_len", {28'd0, w_errs}, 32'd0);

        // Parity error mid-frame, then recovery with a good frame
        send(8'hAA, 1'b0);
        send(8'h11, 1'b1);
        chk("parity_errs", {28'd0, w_errs}, 32'b1000);
        chk("parity_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        chk("parity_recover_data",  frm_data, 32'h01020304);
        chk("parity_recover_valid", {31'd0, frm_valid}, 32'd1);
        @(negedge clk);

        // Timeout: pulse lands 15 edges after the last sampled byte
        send(8'hAA, 1'b0);
        send(8'h01, 1'b0);
        repeat (14) @(negedge clk);
        chk("timeout_early", {28'd0, w_errs}, 32'd0);
        chk("timeout_early_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("timeout_errs", {28'd0, w_errs}, 32'b0010);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("timeout_pulse_len", {28'd0, w_errs}, 32'd0);

        // Byte arriving on the timeout cycle wins
        send(8'hAA, 1'b0);
        send(8'h01, 1'b0);
        repeat (14) @(negedge clk);
        send(8'h02, 1'b0);
        chk("to_suppress_errs", {28'd0, w_errs}, 32'd0);
        chk("to_suppress_busy", {31'd0, busy}, 32'd1);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h0A, 1'b0);
        chk("to_suppress_data", frm_data, 32'h01020304);
        @(negedge clk);

        // Sync value used as payload data is not a resync (sum AA+1+2+3=B0)
        send_frame(8'hAA, 8'h01, 8'h02, 8'h03, 8'hB0);
        chk("sync_as_data", frm_data, 32'hAA010203);
        @(negedge clk);

        // Overrun
        frm_ready = 1'b0;
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
        chk("ovr_first_data", frm_data, 32'hFFFFFFFF);
        send_frame(8'h00, 8'h00, 8'h00, 8'h01, 8'h01);
        chk("ovr_errs",  {28'd0, w_errs}, 32'b0001);
        chk("ovr_held",  frm_data, 32'hFFFFFFFF);
        chk("ovr_valid", {31'd0, frm_valid}, 32'd1);
        @(negedge clk);
        chk("ovr_pulse_len", {28'd0, w_errs}, 32'd0);
        send(8'hAA, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        frm_ready = 1'b1;
        send(8'h01, 1'b0);
        chk("replace_data",  frm_data, 32'h00000001);
        chk("replace_valid", {31'd0, frm_valid}, 32'd1);
        chk("replace_errs",  {28'd0, w_errs}, 32'd0);
        @(negedge clk);
        chk("replace_drain", {31'd0, frm_valid}, 32'd0);

        // Asynchronous reset mid-frame
        frm_ready = 1'b0;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        send(8'hAA, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data",  frm_data, 32'h0);
        chk("arst_valid", {31'd0, frm_valid}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h0A, 1'b0);
        chk("arst_ignore_busy",  {31'd0, busy}, 32'd0);
        chk("arst_ignore_valid", {31'd0, frm_valid}, 32'd0);
        chk("arst_ignore_errs",  {28'd0, w_errs}, 32'd0);
        frm_ready = 1'b1;
        send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        chk("arst_next_data",  frm_data, 32'h05060708);
        chk("arst_next_valid", {31'd0, frm_valid}, 32'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
